// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : uart_pkg                                                      |
// | Purpose  : Shared receiver state encoding, oversampling constants and a  |
// |            3-input majority helper.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] CNT_LAST   = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_sampler                                               |
// | Purpose  : rx synchroniser plus 3-sample majority vote around mid-bit.   |
// |            bit_stb marks the decision cycle (cnt==9); bit_val is the     |
// |            majority of the synchronised line at cnt 7, 8 and 9.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_16x_bps,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic [3:0] i_cnt,
  input  logic       i_active,
  output logic       o_sync_rx,
  output logic       o_bit_val,
  output logic       o_bit_stb
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_lo;
  logic                   r_s_mid;

  // Synchroniser chain; resets to the idle (high) level so reset release never looks like a start bit
  always_ff @(posedge clk_16x_bps or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign o_sync_rx = r_sync[SYNC_STAGES-1];

  // Hold the first two mid-bit samples; the third is the live line at the decision cycle
  always_ff @(posedge clk_16x_bps or negedge rst_n) begin
    if (!rst_n) begin
      r_s_lo  <= 1'b1;
      r_s_mid <= 1'b1;
    end else begin
      if (i_cnt == SAMPLE_LO)  r_s_lo  <= o_sync_rx;
      if (i_cnt == SAMPLE_MID) r_s_mid <= o_sync_rx;
    end
  end

  assign o_bit_stb = i_active && (i_cnt == SAMPLE_HI);
  assign o_bit_val = maj3(r_s_lo, r_s_mid, o_sync_rx);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_param                                                 |
// | Purpose  : Parametrised 16x-oversampled UART receiver with runtime       |
// |            parity/stop mode, parity/framing/overrun flags and a          |
// |            valid/ready output. Optional line-break detection is built    |
// |            when UART_RX_BREAK_DET_EN is defined.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_16x_bps,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 break_det
);

`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  localparam int             BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_t              r_state;
  logic [3:0]             r_cnt;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_two_stop;
  logic                   r_stop2;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_zero;
  logic                   r_armed;
  logic                   r_done;
  logic                   r_brk;

  logic                   w_sync_rx;
  logic                   w_bit_val;
  logic                   w_bit_stb;
  logic                   w_last_zero;
  logic                   w_load;
  logic                   w_ovr_set;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk_16x_bps (clk_16x_bps),
    .rst_n       (rst_n),
    .i_rx        (rx),
    .i_cnt       (r_cnt),
    .i_active    (r_state != IDLE),
    .o_sync_rx   (w_sync_rx),
    .o_bit_val   (w_bit_val),
    .o_bit_stb   (w_bit_stb)
  );

  // A frame is a break only if every bit so far and the final stop bit are all low
  assign w_last_zero = r_zero & ~w_bit_val;

  // Frame FSM: start qualification, data shift, parity check, stop bit(s) with early return
  always_ff @(posedge clk_16x_bps or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_zero     <= 1'b0;
      r_armed    <= 1'b1;
      r_done     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_brk  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_armed) begin
            if (w_sync_rx) r_armed <= 1'b1;
          end else if (!w_sync_rx) begin
            r_state    <= START;
            r_par_en   <= parity_en;
            r_par_odd  <= parity_odd;
            r_two_stop <= two_stop;
            r_stop2    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_zero     <= 1'b1;
          end
        end
        START: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_bit_stb && w_bit_val) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= DATA;
            r_bit   <= '0;
          end
        end
        DATA: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_bit_stb) begin
            r_shift[r_bit] <= w_bit_val;
            if (w_bit_val) r_zero <= 1'b0;
          end
          if (r_cnt == CNT_LAST) begin
            if (r_bit == LAST_BIT) r_state <= r_par_en ? PARITY : STOP;
            else                   r_bit   <= r_bit + BIT_W'(1);
          end
        end
        PARITY: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_bit_stb) begin
            r_perr <= ((^r_shift) ^ w_bit_val) != r_par_odd;
            if (w_bit_val) r_zero <= 1'b0;
          end
          if (r_cnt == CNT_LAST) r_state <= STOP;
        end
        STOP: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_bit_stb) begin
            if (!w_bit_val) r_ferr <= 1'b1;
            else            r_zero <= 1'b0;
            if (r_two_stop && !r_stop2) begin
              r_stop2 <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
              if (BRK_EN && w_last_zero) begin
                r_brk   <= 1'b1;
                r_armed <= 1'b0;
              end else begin
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_load    = r_done && (!rx_valid || rx_ready);
  assign w_ovr_set = r_done && rx_valid && !rx_ready;

  // Output word register and valid/ready handshake; a fresh load wins over consumption
  always_ff @(posedge clk_16x_bps or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (w_load) begin
      rx_data    <= r_shift;
      rx_valid   <= 1'b1;
      parity_err <= r_perr;
      frame_err  <= r_ferr;
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun in the same cycle as err_clr keeps it set
  always_ff @(posedge clk_16x_bps or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (w_ovr_set) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end
  end

  assign break_det = r_brk;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_param                                              |
// | Purpose  : Scoreboard bench for uart_rx_param: randomised and directed   |
// |            frames, expected words queued at stimulus time and popped by  |
// |            a monitor on each valid/ready handshake.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_param;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int BIT_T       = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rx;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 two_stop;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 err_clr;
  logic                 break_det;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_BITS   (DATA_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_16x_bps (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .two_stop    (two_stop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .err_clr     (err_clr),
    .break_det   (break_det)
  );

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t0       = 0;
  int   rise_cyc = -1;
  int   vcnt     = 0;
  int   brk_cnt  = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word, tracks valid rise and break pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid) vcnt++;
      if (break_det) brk_cnt++;
      if (rx_valid && rx_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", rx_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", 32'(rx_data), 32'(e.data));
          chk("word_parity_err", 32'(parity_err), 32'(e.perr));
          chk("word_frame_err", 32'(frame_err), 32'(e.ferr));
        end
      end
      prev_valid = rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Drives one frame; the expected word follows the line rules, not the receiver internals
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic pe, input logic po,
                            input logic ts, input logic flip_par, input logic bad_s1,
                            input logic bad_s2, input logic deliver, input int gap_bits);
    logic pbit;
    exp_t e;
    pbit = (^d) ^ po ^ flip_par;
    if (deliver) begin
      e.data = d;
      e.perr = pe && (((^d) ^ pbit) != po);
      e.ferr = bad_s1 || (ts && bad_s2);
      q.push_back(e);
    end
    @(negedge clk);
    parity_en = pe; parity_odd = po; two_stop = ts;
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    repeat (BIT_T) @(negedge clk);
    // mode pins are only sampled at frame start; scramble them mid-frame
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    two_stop   = 1'($urandom);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      repeat (BIT_T) @(negedge clk);
    end
    if (pe) begin
      rx = pbit;
      repeat (BIT_T) @(negedge clk);
    end
    rx = ~bad_s1;
    repeat (BIT_T) @(negedge clk);
    if (ts) begin
      rx = ~bad_s2;
      repeat (BIT_T) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap_bits * BIT_T) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DATA_BITS-1:0] d;
    logic pe, po, ts, fp, bs1, bs2;
    int   v0, b0;

    rst_n = 1'b0; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    rx_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_break_det", 32'(break_det), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: latency from first low sample and single-cycle valid with ready held high
    v0 = vcnt; rise_cyc = -1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    chk("t1_latency", 32'(rise_cyc - t0 - 1), 32'(11 + SYNC_STAGES + 16 * (1 + DATA_BITS)));
    chk("t1_valid_cycles", 32'(vcnt - v0), 32'd1);
    drain("t1_drain");

    // even parity on 0x07: wrong parity bit, then correct one
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drain("t2_drain");

    // short low glitch must be rejected; a following frame decodes normally
    v0 = vcnt;
    @(negedge clk); rx = 1'b0;
    repeat (5) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_glitch_no_valid", 32'(vcnt - v0), 32'd0);
    send_frame(8'h5E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drain("t3_drain");

    // two stop bits with the second one low
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain("t4_drain");

    // randomised frames against the line-rule model
    for (int k = 0; k < 24; k++) begin
      d   = DATA_BITS'($urandom);
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      ts  = 1'($urandom_range(0, 1));
      fp  = pe && ($urandom_range(0, 3) == 0);
      bs1 = (d != '0) && ($urandom_range(0, 4) == 0);
      bs2 = ts && (d != '0) && ($urandom_range(0, 3) == 0);
      send_frame(d, pe, po, ts, fp, bs1, bs2, 1'b1, int'($urandom_range(0, 2)));
    end
    drain("rand_drain");

    // overrun: second word dropped while first is unaccepted, then cleared
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk("t5_valid_held", 32'(rx_valid), 32'd1);
    chk("t5_data_kept", 32'(rx_data), 32'h11);
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_overrun_clr", 32'(overrun), 32'd0);
    rx_ready = 1'b1;
    drain("t5_drain");

    // line held low for just over 20 bit times
    parity_en = 1'b0; two_stop = 1'b0;
    v0 = vcnt; b0 = brk_cnt;
`ifdef UART_RX_BREAK_DET_EN
    // one break pulse and nothing delivered; receiver waits for the line to go high
`else
    // two complete all-zero frames fit inside the low period; the third start bit
    // lies inside the low period and its data/stop bits see the released (high) line
    begin
      exp_t e;
      e.data = '0; e.perr = 1'b0; e.ferr = 1'b1;
      q.push_back(e);
      q.push_back(e);
      e.data = '1; e.perr = 1'b0; e.ferr = 1'b0;
      q.push_back(e);
    end
`endif
    @(negedge clk); rx = 1'b0;
    repeat (20 * BIT_T + 4) @(negedge clk);
    rx = 1'b1;
    repeat (40 * BIT_T) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
    chk("t6_break_pulses", 32'(brk_cnt - b0), 32'd1);
    chk("t6_no_valid", 32'(vcnt - v0), 32'd0);
`else
    chk("t6_break_pulses", 32'(brk_cnt - b0), 32'd0);
`endif
    drain("t6_drain");

    // asynchronous reset in the middle of a frame clears every output at once
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t7_pre_frame_err", 32'(frame_err), 32'd1);
    chk("t7_pre_overrun", 32'(overrun), 32'd1);
    @(negedge clk); rx = 1'b0;
    repeat (3 * BIT_T) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("t7_rst_rx_data", 32'(rx_data), 32'd0);
    chk("t7_rst_frame_err", 32'(frame_err), 32'd0);
    chk("t7_rst_parity_err", 32'(parity_err), 32'd0);
    chk("t7_rst_overrun", 32'(overrun), 32'd0);
    chk("t7_rst_break_det", 32'(break_det), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * BIT_T) @(negedge clk);
    chk("t7_no_word_after_reset", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
